// File: rtl/srl_uart_pkg.sv
// Shared definitions for the serial port: register offsets, bit positions, FSM states.
package srl_uart_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIVLO  = 3'd3;
    localparam logic [2:0] REG_DIVHI  = 3'd4;

    localparam int ST_RXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_TXIDLE  = 2;
    localparam int ST_OVRERR  = 3;
    localparam int ST_FRMERR  = 4;

    localparam int CT_RXIRQEN = 0;
    localparam int CT_TXIRQEN = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

endpackage

// File: rtl/srl_uart_rx.sv
// 8N1 receiver: rxd synchroniser, oversampling FSM and shifter.
// state    | meaning
// RX_IDLE  | waiting for a low level at a baud tick
// RX_START | counting to mid start bit, rejects glitches
// RX_DATA  | sampling 8 data bits LSB first, one per OVS ticks
// RX_STOP  | sampling the stop bit, then reporting the byte
module srl_uart_rx
    import srl_uart_pkg::*;
#(
    parameter int OVS      = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rxd,
    output logic [7:0] rxByte,
    output logic       rxDone,
    output logic       frameOk
);
    localparam int CW = $clog2(OVS);

    logic [SYNC_LEN-1:0] syncReg;
    logic                rxs;
    rxState_t            state;
    logic [CW-1:0]       cnt;
    logic [2:0]          bitIdx;
    logic [7:0]          shift;

    assign rxs = syncReg[SYNC_LEN-1];

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) syncReg <= '1;
        else      syncReg <= {syncReg[SYNC_LEN-2:0], rxd};
    end

    // Receive FSM, advanced only on baud ticks; rxDone is a one-clk report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bitIdx  <= '0;
            shift   <= '0;
            rxByte  <= '0;
            rxDone  <= 1'b0;
            frameOk <= 1'b0;
        end else begin
            rxDone <= 1'b0;
            if (tick) begin
                case (state)
                    RX_IDLE: begin
                        if (!rxs) begin
                            state <= RX_START;
                            cnt   <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt == CW'(OVS/2 - 1)) begin
                            cnt    <= '0;
                            bitIdx <= '0;
                            state  <= rxs ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (cnt == CW'(OVS - 1)) begin
                            cnt   <= '0;
                            shift <= {rxs, shift[7:1]};
                            if (bitIdx == 3'd7) state <= RX_STOP;
                            else                bitIdx <= bitIdx + 3'd1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (cnt == CW'(OVS - 1)) begin
                            cnt     <= '0;
                            state   <= RX_IDLE;
                            rxDone  <= 1'b1;
                            frameOk <= rxs;
                            rxByte  <= shift;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/srl_uart.sv
// Serial port peripheral: bus registers, baud generator, 8N1 transmitter, IRQ.
// state    | meaning
// TX_IDLE  | line high, waiting for a byte in the holding register
// TX_START | start bit (low) for OVS ticks
// TX_DATA  | 8 data bits LSB first, OVS ticks each
// TX_STOP  | stop bit (high); chains straight into a new START if a byte waits
module srl_uart
    import srl_uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd51,
    parameter int          OVS       = 16,
    parameter int          SYNC_LEN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sysClk,
    input  logic       srlEn,
    input  logic       rw,
    input  logic [2:0] adrBusLo,
    input  logic [7:0] datBus,
    output logic [7:0] datOut,
    output logic       datOe,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int CW = $clog2(OVS);

    logic          sysClkD, fall, busWr, busRd, dataWr, dataRd, statWr;
    logic [15:0]   div, baudCnt;
    logic          tick;
    logic [7:0]    txHold, rxHold, txShift, regMux, rxByte;
    logic          txEmpty, rxFull, ovrErr, frmErr, rxIrqEn, txIrqEn;
    logic          txLoad, txIdle, txLast, rxDone, frameOk;
    txState_t      txState;
    logic [CW-1:0] txCnt;
    logic [2:0]    txBit;

    assign fall   = sysClkD & ~sysClk;
    assign busWr  = fall & ~srlEn & ~rw;
    assign busRd  = fall & ~srlEn & rw;
    assign dataWr = busWr & (adrBusLo == REG_DATA);
    assign dataRd = busRd & (adrBusLo == REG_DATA);
    assign statWr = busWr & (adrBusLo == REG_STATUS);

    assign tick   = (baudCnt == 16'd0);
    assign txLast = (txCnt == CW'(OVS - 1));
    // A waiting byte is picked up at a tick, from IDLE or at the end of STOP.
    assign txLoad = tick & ~txEmpty &
                    ((txState == TX_IDLE) | ((txState == TX_STOP) & txLast));
    assign txIdle = (txState == TX_IDLE) & txEmpty;

    // Delay sysClk one clk to find the falling edge that commits a CPU cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sysClkD <= 1'b0;
        else      sysClkD <= sysClk;
    end

    // Baud down-counter; a new divider only takes effect at the next reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      baudCnt <= DIV_RESET;
        else if (tick) baudCnt <= div;
        else           baudCnt <= baudCnt - 16'd1;
    end

    // Transmit FSM with registered txd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
            txd     <= 1'b1;
        end else if (txLoad) begin
            txState <= TX_START;
            txCnt   <= '0;
            txShift <= txHold;
            txd     <= 1'b0;
        end else if (tick) begin
            case (txState)
                TX_IDLE: txd <= 1'b1;
                TX_START: begin
                    if (txLast) begin
                        txCnt   <= '0;
                        txBit   <= '0;
                        txState <= TX_DATA;
                        txd     <= txShift[0];
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (txLast) begin
                        txCnt <= '0;
                        if (txBit == 3'd7) begin
                            txState <= TX_STOP;
                            txd     <= 1'b1;
                        end else begin
                            txBit   <= txBit + 3'd1;
                            txShift <= {1'b0, txShift[7:1]};
                            txd     <= txShift[1];
                        end
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (txLast) begin
                        txCnt   <= '0;
                        txState <= TX_IDLE;
                        txd     <= 1'b1;
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end

    // Register file; later assignments give the required priority on collisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txHold  <= '0;
            rxHold  <= '0;
            txEmpty <= 1'b1;
            rxFull  <= 1'b0;
            ovrErr  <= 1'b0;
            frmErr  <= 1'b0;
            rxIrqEn <= 1'b0;
            txIrqEn <= 1'b0;
            div     <= DIV_RESET;
        end else begin
            if (busWr) begin
                case (adrBusLo)
                    REG_DATA:  txHold <= datBus;
                    REG_CTRL: begin
                        rxIrqEn <= datBus[CT_RXIRQEN];
                        txIrqEn <= datBus[CT_TXIRQEN];
                    end
                    REG_DIVLO: div[7:0]  <= datBus;
                    REG_DIVHI: div[15:8] <= datBus;
                    default: ;
                endcase
            end
            if (dataWr)      txEmpty <= 1'b0;
            else if (txLoad) txEmpty <= 1'b1;
            if (statWr) begin
                ovrErr <= 1'b0;
                frmErr <= 1'b0;
            end
            if (dataRd) rxFull <= 1'b0;
            if (rxDone) begin
                if (!frameOk) begin
                    frmErr <= 1'b1;
                end else if (rxFull && !dataRd) begin
                    ovrErr <= 1'b1;
                end else begin
                    rxHold <= rxByte;
                    rxFull <= 1'b1;
                end
            end
        end
    end

    // Read mux; driven as zero whenever the bus is not being read.
    always_comb begin
        regMux = 8'h00;
        case (adrBusLo)
            REG_DATA:   regMux = rxHold;
            REG_STATUS: regMux = {3'b000, frmErr, ovrErr, txIdle, txEmpty, rxFull};
            REG_CTRL:   regMux = {6'b000000, txIrqEn, rxIrqEn};
            REG_DIVLO:  regMux = div[7:0];
            REG_DIVHI:  regMux = div[15:8];
            default:    regMux = 8'h00;
        endcase
    end

    assign datOe  = ~srlEn & rw & sysClk;
    assign datOut = datOe ? regMux : 8'h00;

    // Registered active-low interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b1;
        else      irq <= ~((rxFull & rxIrqEn) | (txEmpty & txIrqEn));
    end

    srl_uart_rx #(
        .OVS      (OVS),
        .SYNC_LEN (SYNC_LEN)
    ) uRx (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .rxd     (rxd),
        .rxByte  (rxByte),
        .rxDone  (rxDone),
        .frameOk (frameOk)
    );

endmodule

// File: tb/tb_srl_uart.sv
// Bench for srl_uart: register table, TX bit scoreboard, loopback RX scoreboard, corner sequences.
module tb_srl_uart;
    import srl_uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sysClk = 1'b0;
    logic       srlEn = 1'b1;
    logic       rw = 1'b1;
    logic [2:0] adrBusLo = 3'd0;
    logic [7:0] datBus = 8'h00;
    logic [7:0] datOut;
    logic       datOe;
    logic       txd, irq;
    logic       loopEn = 1'b1;
    logic       rxdDrv = 1'b1;
    logic       rxdLine;

    int checks = 0;
    int errors = 0;

    logic       bitQ[$];
    logic [7:0] rxQ[$];

    typedef struct {
        logic       doWr;
        logic [2:0] adr;
        logic [7:0] wdat;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs[13];

    assign rxdLine = loopEn ? txd : rxdDrv;

    always #5 clk = ~clk;

    srl_uart dut (
        .clk      (clk),
        .rst      (rst),
        .sysClk   (sysClk),
        .srlEn    (srlEn),
        .rw       (rw),
        .adrBusLo (adrBusLo),
        .datBus   (datBus),
        .datOut   (datOut),
        .datOe    (datOe),
        .rxd      (rxdLine),
        .txd      (txd),
        .irq      (irq)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        srlEn = 1'b0; rw = 1'b0; adrBusLo = a; datBus = d; sysClk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sysClk = 1'b0;
        @(negedge clk);
        srlEn = 1'b1; rw = 1'b1;
    endtask

    task automatic busRead(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        srlEn = 1'b0; rw = 1'b1; adrBusLo = a; sysClk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d = datOut;
        sysClk = 1'b0;
        @(negedge clk);
        srlEn = 1'b1;
    endtask

    task automatic waitStatus(input logic [7:0] mask, input logic [7:0] val,
                              input int budget, input string nm);
        logic [7:0] s;
        int n;
        n = 0;
        busRead(REG_STATUS, s);
        while (((s & mask) != val) && (n < budget)) begin
            busRead(REG_STATUS, s);
            n += 4;
        end
        if ((s & mask) != val) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: status %h, wanted %h under mask %h", nm, s, val, mask);
        end
    endtask

    task automatic waitTxdLow(input int budget, input string nm);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: txd %b, wanted 0", nm, txd);
        end
    endtask

    task automatic checkRxData(input string nm);
        logic [7:0] d, e;
        busRead(REG_DATA, d);
        if (rxQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h, expected queue empty", nm, d);
        end else begin
            e = rxQ.pop_front();
            check(nm, {8'h00, d}, {8'h00, e});
        end
    endtask

    task automatic driveFrame(input logic [7:0] b, input logic stopLvl);
        @(negedge clk);
        rxdDrv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxdDrv = b[i];
            repeat (64) @(negedge clk);
        end
        rxdDrv = stopLvl;
        repeat (40) @(negedge clk);
        rxdDrv = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] txByte;

        vecs[0]  = '{1'b0, REG_STATUS, 8'h00, 8'h06};
        vecs[1]  = '{1'b0, REG_DIVLO,  8'h00, 8'h33};
        vecs[2]  = '{1'b0, REG_DIVHI,  8'h00, 8'h00};
        vecs[3]  = '{1'b0, REG_CTRL,   8'h00, 8'h00};
        vecs[4]  = '{1'b0, REG_DATA,   8'h00, 8'h00};
        vecs[5]  = '{1'b1, REG_CTRL,   8'hFF, 8'h03};
        vecs[6]  = '{1'b1, REG_CTRL,   8'h00, 8'h00};
        vecs[7]  = '{1'b1, REG_DIVHI,  8'h12, 8'h12};
        vecs[8]  = '{1'b1, REG_DIVHI,  8'h00, 8'h00};
        vecs[9]  = '{1'b1, REG_DIVLO,  8'h03, 8'h03};
        vecs[10] = '{1'b1, 3'd5,       8'hAA, 8'h00};
        vecs[11] = '{1'b1, 3'd7,       8'h55, 8'h00};
        vecs[12] = '{1'b1, REG_STATUS, 8'hFF, 8'h06};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", {15'd0, txd}, 16'd1);
        check("rst_irq", {15'd0, irq}, 16'd1);
        check("rst_datOe", {15'd0, datOe}, 16'd0);
        check("rst_datOut", {8'h00, datOut}, 16'h0000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Register table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].doWr) busWrite(vecs[i].adr, vecs[i].wdat);
            busRead(vecs[i].adr, rd);
            check($sformatf("reg_vec%0d", i), {8'h00, rd}, {8'h00, vecs[i].expRd});
        end
        // Let any long reload from the temporary DIVHI value expire.
        repeat (6000) @(negedge clk);

        // TX of $55 with per-bit scoreboard; loopback also receives it
        txByte = 8'h55;
        bitQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitQ.push_back(txByte[i]);
        bitQ.push_back(1'b1);
        rxQ.push_back(txByte);
        busWrite(REG_DATA, txByte);
        waitTxdLow(200, "tx55_start");
        repeat (32) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            logic e;
            e = bitQ.pop_front();
            check($sformatf("tx55_bit%0d", i), {15'd0, txd}, {15'd0, e});
            repeat (64) @(negedge clk);
        end
        busRead(REG_STATUS, rd);
        check("tx55_status_done", {8'h00, rd}, 16'h0007);
        checkRxData("tx55_loop_data");
        busRead(REG_STATUS, rd);
        check("tx55_status_read", {8'h00, rd}, 16'h0006);

        // Loopback $A7
        rxQ.push_back(8'hA7);
        busWrite(REG_DATA, 8'hA7);
        waitStatus(8'h01, 8'h01, 3000, "a7_rxfull");
        checkRxData("a7_data");
        busRead(REG_STATUS, rd);
        check("a7_rxfull_clr", {8'h00, rd & 8'h01}, 16'h0000);
        waitStatus(8'h04, 8'h04, 3000, "a7_txidle");

        // Two frames without a read: first kept, overrun flagged
        rxQ.push_back(8'h11);
        busWrite(REG_DATA, 8'h11);
        waitStatus(8'h02, 8'h02, 200, "ovr_load1");
        busWrite(REG_DATA, 8'h22);
        waitStatus(8'h08, 8'h08, 4000, "ovr_flag");
        waitStatus(8'h04, 8'h04, 1000, "ovr_txidle");
        busRead(REG_STATUS, rd);
        check("ovr_status", {8'h00, rd}, 16'h000F);
        checkRxData("ovr_data");
        busWrite(REG_STATUS, 8'h00);
        busRead(REG_STATUS, rd);
        check("ovr_cleared", {8'h00, rd}, 16'h0006);

        // Glitch of 4 ticks: nothing received
        loopEn = 1'b0;
        @(negedge clk);
        rxdDrv = 1'b0;
        repeat (16) @(negedge clk);
        rxdDrv = 1'b1;
        repeat (400) @(negedge clk);
        busRead(REG_STATUS, rd);
        check("false_start", {8'h00, rd}, 16'h0006);

        // Bench-driven good frame
        rxQ.push_back(8'hC3);
        driveFrame(8'hC3, 1'b1);
        repeat (100) @(negedge clk);
        checkRxData("ext_frame_data");

        // Stop bit low: framing error, no byte
        driveFrame(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        busRead(REG_STATUS, rd);
        check("frm_status", {8'h00, rd}, 16'h0016);
        busWrite(REG_STATUS, 8'h00);
        busRead(REG_STATUS, rd);
        check("frm_cleared", {8'h00, rd}, 16'h0006);

        // Interrupts
        loopEn = 1'b1;
        busWrite(REG_CTRL, 8'h01);
        repeat (2) @(negedge clk);
        check("irq_rx_idle", {15'd0, irq}, 16'd1);
        rxQ.push_back(8'h5A);
        busWrite(REG_DATA, 8'h5A);
        begin
            int n;
            n = 0;
            while (irq !== 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        check("irq_rx_low", {15'd0, irq}, 16'd0);
        busRead(REG_STATUS, rd);
        check("irq_rxfull", {8'h00, rd & 8'h01}, 16'h0001);
        checkRxData("irq_data");
        repeat (2) @(negedge clk);
        check("irq_rx_release", {15'd0, irq}, 16'd1);
        waitStatus(8'h04, 8'h04, 1000, "irq_txidle");
        busWrite(REG_CTRL, 8'h02);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", {15'd0, irq}, 16'd0);
        busWrite(REG_CTRL, 8'h00);
        repeat (2) @(negedge clk);
        check("irq_off", {15'd0, irq}, 16'd1);

        // Reset in the middle of a frame
        busWrite(REG_DATA, 8'h00);
        waitTxdLow(200, "midrst_start");
        repeat (100) @(negedge clk);
        check("midrst_txd_before", {15'd0, txd}, 16'd0);
        rst = 1'b0;
        #1;
        check("midrst_txd", {15'd0, txd}, 16'd1);
        check("midrst_irq", {15'd0, irq}, 16'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        busRead(REG_STATUS, rd);
        check("midrst_status", {8'h00, rd}, 16'h0006);
        busRead(REG_DIVLO, rd);
        check("midrst_divlo", {8'h00, rd}, 16'h0033);
        busRead(REG_DATA, rd);
        check("midrst_rxhold", {8'h00, rd}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
